// File: rtl/wm8731_cfg_seq.sv
// WM8731 codec configuration sequencer.
// After reset release (or a start pulse once finished) it waits 256 bus ticks,
// then writes eleven 16-bit register words to the codec over I2C, one
// START/addr/hi/lo/STOP frame per word followed by a 4-tick gap.
// Optional macro WM8731_ACK_CHECK_EN: honour NACKs, retry a word up to four
// times and flag cfg_err if it never gets acknowledged.
module wm8731_cfg_seq #(
    parameter int         CLOCK_REF = 18432000,
    parameter int         I2C_FREQ  = 100000,
    parameter logic [6:0] DEV_ADDR  = 7'h1A
) (
    input  logic clock_ref,
    input  logic reset_n,
    input  logic start,
    output logic i2c_sclk,
    inout  wire  i2c_sdat,
    output logic cfg_busy,
    output logic cfg_done,
    output logic cfg_err
);

    // one tick per quarter SCL period
    localparam int Q     = CLOCK_REF / (I2C_FREQ * 4);
    localparam int QQ    = (Q < 1) ? 1 : Q;
    localparam int DIV_W = (QQ > 1) ? $clog2(QQ) : 1;

    typedef enum logic [3:0] {
        IDLE, PWRUP, START, BIT, ACK, STOP, GAP, DONE, ERR
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [1:0]         phase_q, phase_d;
    logic [2:0]         bit_q, bit_d;
    logic [1:0]         byte_q, byte_d;
    logic [3:0]         word_q, word_d;
    logic [7:0]         pwr_q, pwr_d;
    logic               nack_q, nack_d;
    logic [1:0]         retry_q, retry_d;
    logic               sclk_q, sclk_d;
    logic               sda_low_q, sda_low_d;

    logic               tick;
    logic               busy;
    logic [15:0]        cur_word;
    logic [7:0]         cur_byte;
    logic               cur_bit;

    // codec register words {reg[6:0], data[8:0]} in transmit order
    function automatic logic [15:0] cfg_word(input logic [3:0] idx);
        case (idx)
            4'd0:    cfg_word = 16'h1E00;
            4'd1:    cfg_word = 16'h0017;
            4'd2:    cfg_word = 16'h0217;
            4'd3:    cfg_word = 16'h0479;
            4'd4:    cfg_word = 16'h0679;
            4'd5:    cfg_word = 16'h0812;
            4'd6:    cfg_word = 16'h0A00;
            4'd7:    cfg_word = 16'h0C00;
            4'd8:    cfg_word = 16'h0E01;
            4'd9:    cfg_word = 16'h1002;
            4'd10:   cfg_word = 16'h1201;
            default: cfg_word = 16'h0000;
        endcase
    endfunction

    assign busy = (state_q == PWRUP) || (state_q == START) || (state_q == BIT) ||
                  (state_q == ACK)   || (state_q == STOP)  || (state_q == GAP);

    // next state, counters, and the bus levels for the step being entered
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        phase_d   = phase_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        word_d    = word_q;
        pwr_d     = pwr_q;
        nack_d    = nack_q;
        retry_d   = retry_q;
        sclk_d    = 1'b1;
        sda_low_d = 1'b0;
        cur_word  = 16'h0000;
        cur_byte  = 8'h00;
        cur_bit   = 1'b1;

        tick = (div_q == DIV_W'(QQ - 1));
        // divider only runs while a sequence is active so each run starts aligned
        if (busy) div_d = tick ? '0 : div_q + DIV_W'(1);
        else      div_d = '0;

        case (state_q)
            IDLE: begin
                state_d = PWRUP;
                pwr_d   = '0;
                word_d  = '0;
                retry_d = '0;
            end
            DONE, ERR: begin
                if (start) begin
                    state_d = PWRUP;
                    pwr_d   = '0;
                    word_d  = '0;
                    retry_d = '0;
                end
            end
            PWRUP: begin
                if (tick) begin
                    if (pwr_q == 8'hFF) begin
                        state_d = START;
                        phase_d = '0;
                    end else begin
                        pwr_d = pwr_q + 8'd1;
                    end
                end
            end
            START: begin
                if (tick) begin
                    phase_d = phase_q + 2'd1;
                    if (phase_q == 2'd3) begin
                        state_d = BIT;
                        bit_d   = '0;
                        byte_d  = '0;
                        nack_d  = 1'b0;
                    end
                end
            end
            BIT: begin
                if (tick) begin
                    phase_d = phase_q + 2'd1;
                    if (phase_q == 2'd3) begin
                        if (bit_q == 3'd7) state_d = ACK;
                        else               bit_d   = bit_q + 3'd1;
                    end
                end
            end
            ACK: begin
                if (tick) begin
                    phase_d = phase_q + 2'd1;
`ifdef WM8731_ACK_CHECK_EN
                    if (phase_q == 2'd2) nack_d = i2c_sdat;
`endif
                    if (phase_q == 2'd3) begin
                        // a NACK cuts the frame short after the current bit
                        if (nack_q || byte_q == 2'd2) begin
                            state_d = STOP;
                        end else begin
                            state_d = BIT;
                            byte_d  = byte_q + 2'd1;
                            bit_d   = '0;
                        end
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    phase_d = phase_q + 2'd1;
                    if (phase_q == 2'd3) state_d = GAP;
                end
            end
            GAP: begin
                if (tick) begin
                    phase_d = phase_q + 2'd1;
                    if (phase_q == 2'd3) begin
                        if (nack_q) begin
                            if (retry_q == 2'd3) begin
                                state_d = ERR;
                            end else begin
                                retry_d = retry_q + 2'd1;
                                state_d = START;
                            end
                        end else begin
                            retry_d = '0;
                            if (word_q == 4'd10) begin
                                state_d = DONE;
                            end else begin
                                word_d  = word_q + 4'd1;
                                state_d = START;
                            end
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        cur_word = cfg_word(word_d);
        case (byte_d)
            2'd0:    cur_byte = {DEV_ADDR, 1'b0};
            2'd1:    cur_byte = cur_word[15:8];
            default: cur_byte = cur_word[7:0];
        endcase
        cur_bit = cur_byte[3'd7 - bit_d];

        // SCL low on q0/q3 of data bits; SDA only moves while SCL is low except
        // for the START fall (q2) and the STOP rise (q2)
        case (state_d)
            START: begin
                sclk_d    = (phase_d != 2'd3);
                sda_low_d = phase_d[1];
            end
            BIT: begin
                sclk_d    = (phase_d == 2'd1) || (phase_d == 2'd2);
                sda_low_d = ~cur_bit;
            end
            ACK: begin
                sclk_d    = (phase_d == 2'd1) || (phase_d == 2'd2);
                sda_low_d = 1'b0;
            end
            STOP: begin
                sclk_d    = (phase_d != 2'd0);
                sda_low_d = ~phase_d[1];
            end
            default: begin
                sclk_d    = 1'b1;
                sda_low_d = 1'b0;
            end
        endcase
    end

    // state and bus registers; reset parks the bus idle and forgets the frame
    always_ff @(posedge clock_ref or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            div_q     <= '0;
            phase_q   <= '0;
            bit_q     <= '0;
            byte_q    <= '0;
            word_q    <= '0;
            pwr_q     <= '0;
            nack_q    <= 1'b0;
            retry_q   <= '0;
            sclk_q    <= 1'b1;
            sda_low_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            phase_q   <= phase_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            word_q    <= word_d;
            pwr_q     <= pwr_d;
            nack_q    <= nack_d;
            retry_q   <= retry_d;
            sclk_q    <= sclk_d;
            sda_low_q <= sda_low_d;
        end
    end

    assign i2c_sclk = sclk_q;
    assign i2c_sdat = sda_low_q ? 1'b0 : 1'bz;
    assign cfg_busy = busy;
    assign cfg_done = (state_q == DONE);
`ifdef WM8731_ACK_CHECK_EN
    assign cfg_err  = (state_q == ERR);
`else
    assign cfg_err  = 1'b0;
`endif

endmodule

// File: tb/tb_wm8731_cfg_seq.sv
// Bench for wm8731_cfg_seq: an I2C bus monitor/codec model decodes frames and
// answers ACK/NACK, a timeline model predicts busy/done/err every cycle.
module tb_wm8731_cfg_seq;

    localparam int Q = 2;   // 800 kHz ref / (100 kHz * 4)

    localparam logic [15:0] TBL [0:10] = '{16'h1E00, 16'h0017, 16'h0217, 16'h0479,
        16'h0679, 16'h0812, 16'h0A00, 16'h0C00, 16'h0E01, 16'h1002, 16'h1201};

    logic clk = 1'b0;
    logic reset_n;
    logic start;
    logic i2c_sclk;
    wire  sda_bus;
    logic cfg_busy, cfg_done, cfg_err;
    logic codec_drv = 1'b0;

    pullup (sda_bus);
    assign sda_bus = codec_drv ? 1'b0 : 1'bz;

    wm8731_cfg_seq #(.CLOCK_REF(800000), .I2C_FREQ(100000), .DEV_ADDR(7'h1A)) dut (
        .clock_ref(clk), .reset_n(reset_n), .start(start), .i2c_sclk(i2c_sclk),
        .i2c_sdat(sda_bus), .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- timeline model: busy from run start edge for T ticks ----------------
    int   m_c0 = 0;
    int   m_T = 0;
    logic m_err = 1'b0;
    logic m_en = 1'b0;

    always @(posedge clk) begin
        int   endc;
        logic eb, ed, ee;
        #1;
        if (reset_n === 1'b1 && m_en) begin
            endc = m_c0 + m_T * Q;
            eb = (cyc >= m_c0) && (cyc < endc);
            ed = (cyc >= endc) && !m_err;
            ee = (cyc >= endc) && m_err;
            chk("flags_bde", {29'd0, cfg_busy, cfg_done, cfg_err}, {29'd0, eb, ed, ee});
        end
    end

    // ---------------- bus monitor + codec ACK model ----------------
    int         nack_mode = 0;   // 0 ack all, 1 nack address of frame nack_frame, 2 nack every address
    int         nack_frame = 0;
    int         viol = 0;
    int         frm_nb[$];
    logic [7:0] frm_addr[$];
    logic [15:0] frm_word[$];
    logic       in_frame = 0, pending = 0, sbit = 0, p_scl = 1, p_sda = 1;
    int         bitcnt = 0, nb = 0;
    logic [7:0] cur = 0;
    logic [7:0] byts [0:3];

    always @(posedge clk) begin
        logic scl_now, sda_now;
        #1;
        scl_now = i2c_sclk;
        sda_now = sda_bus;
        if (reset_n !== 1'b1) begin
            in_frame = 0; pending = 0; codec_drv = 0;
        end else if (scl_now && p_scl && sda_now != p_sda) begin
            if (!sda_now) begin
                if (in_frame) viol++;
                in_frame = 1; bitcnt = 0; nb = 0; pending = 0;
            end else if (in_frame && bitcnt > 0 && bitcnt % 9 == 0) begin
                frm_nb.push_back(nb);
                frm_addr.push_back(byts[0]);
                frm_word.push_back(nb >= 3 ? {byts[1], byts[2]} : 16'h0);
                in_frame = 0; pending = 0;
            end else begin
                viol++;
            end
        end else if (!p_scl && scl_now) begin
            if (in_frame) begin pending = 1; sbit = sda_now; end
        end else if (p_scl && !scl_now && pending) begin
            pending = 0;
            if (bitcnt % 9 < 8) begin
                cur = {cur[6:0], sbit};
                if (bitcnt % 9 == 7) begin
                    if (nb < 4) byts[nb] = cur;
                    codec_drv = !(nb == 0 && (nack_mode == 2 ||
                                 (nack_mode == 1 && frm_nb.size() == nack_frame)));
                    nb++;
                end
            end else begin
                codec_drv = 0;
            end
            bitcnt++;
        end
        p_scl = scl_now;
        p_sda = sda_now;
    end

    // ---------------- helpers ----------------
    task automatic clear_mon();
        frm_nb.delete(); frm_addr.delete(); frm_word.delete();
    endtask

    task automatic begin_run(input int t, input logic e);
        m_c0 = cyc + 1; m_T = t; m_err = e; m_en = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input string name, input int exp_clocks);
        int n = 0;
        while (!(cfg_done || cfg_err) && n < exp_clocks + 200) begin
            @(negedge clk);
            n++;
        end
        if (!(cfg_done || cfg_err)) begin
            checks++; failures++;
            $display("FAIL %s_timeout: no done/err within %0d cycles", name, exp_clocks + 200);
        end else begin
            chk({name, "_len"}, cyc - m_c0, exp_clocks);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic check_words(input string name);
        int k = 0;
        int bad = 0;
        int badaddr = 0;
        foreach (frm_nb[i]) begin
            if (frm_addr[i] !== 8'h34) badaddr++;
            if (frm_nb[i] == 3) begin
                if (k > 10 || frm_word[i] !== TBL[k]) bad++;
                k++;
            end
        end
        chk({name, "_word_errs"}, bad, 0);
        chk({name, "_nwords"}, k, 11);
        chk({name, "_addr_errs"}, badaddr, 0);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int nbad;
        reset_n = 1'b0;
        start   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sclk", i2c_sclk, 1'b1);
        chk("rst_sda", sda_bus, 1'b1);
        chk("rst_flags", {cfg_busy, cfg_done, cfg_err}, 3'b000);

        // run 1: reset release, start pulsed mid-sequence is ignored
        clear_mon();
        begin_run(1576, 1'b0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("busy_after_release", cfg_busy, 1'b1);
        repeat (1000) @(negedge clk);
        pulse_start();
        wait_end("run1", 3152);
        chk("run1_done", {cfg_busy, cfg_done, cfg_err}, 3'b010);
        chk("run1_frames", frm_nb.size(), 11);
        chk("run1_first_word", frm_word[0], 16'h1E00);
        check_words("run1");
        chk("run1_scl_high_viol", viol, 0);

        // run 2: start in DONE clears done and reruns
        clear_mon();
        begin_run(1576, 1'b0);
        pulse_start();
        chk("run2_done_cleared", cfg_done, 1'b0);
        wait_end("run2", 3152);
        chk("run2_frames", frm_nb.size(), 11);
        check_words("run2");

        // run 3: codec NACKs the address of word 3 once
        clear_mon();
        nack_mode = 1; nack_frame = 3;
`ifdef WM8731_ACK_CHECK_EN
        begin_run(1624, 1'b0);
        pulse_start();
        wait_end("run3", 3248);
        chk("run3_frames", frm_nb.size(), 12);
        chk("run3_nacked_len", frm_nb[3], 1);
        chk("run3_retry_word", frm_word[4], 16'h0479);
`else
        begin_run(1576, 1'b0);
        pulse_start();
        wait_end("run3", 3152);
        chk("run3_frames", frm_nb.size(), 11);
`endif
        chk("run3_flags", {cfg_busy, cfg_done, cfg_err}, 3'b010);
        check_words("run3");

        // run 4: codec NACKs every address
        clear_mon();
        nack_mode = 2;
`ifdef WM8731_ACK_CHECK_EN
        begin_run(448, 1'b1);
        pulse_start();
        wait_end("run4", 896);
        chk("run4_frames", frm_nb.size(), 4);
        nbad = 0;
        foreach (frm_nb[i]) if (frm_nb[i] != 1) nbad++;
        chk("run4_short_frames", nbad, 0);
        chk("run4_flags", {cfg_busy, cfg_done, cfg_err}, 3'b001);
`else
        begin_run(1576, 1'b0);
        pulse_start();
        wait_end("run4", 3152);
        chk("run4_frames", frm_nb.size(), 11);
        chk("run4_flags", {cfg_busy, cfg_done, cfg_err}, 3'b010);
`endif

        // run 5: reset mid word 5 (second byte, bit 3, q0: SCL low, SDA low)
        clear_mon();
        nack_mode = 0;
        begin_run(1576, 1'b0);
        pulse_start();
        repeat (908 * Q) @(negedge clk);
        chk("pre_rst_sclk", i2c_sclk, 1'b0);
        chk("pre_rst_sda", sda_bus, 1'b0);
        m_en = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("midrst_sclk", i2c_sclk, 1'b1);
        chk("midrst_sda", sda_bus, 1'b1);
        chk("midrst_flags", {cfg_busy, cfg_done, cfg_err}, 3'b000);
        repeat (5) @(negedge clk);
        clear_mon();
        begin_run(1576, 1'b0);
        reset_n = 1'b1;
        wait_end("run6", 3152);
        chk("run6_first_word", frm_word[0], 16'h1E00);
        chk("run6_frames", frm_nb.size(), 11);
        check_words("run6");
        chk("all_scl_high_viol", viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wm8731_cfg_seq.md
WM8731_CFG_SEQ -- requirements
Module: wm8731_cfg_seq

Interface
REQ-001 SHALL have parameter CLOCK_REF, default 18432000: reference clock frequency in Hz.
REQ-002 SHALL have parameter I2C_FREQ, default 100000: SCL frequency in Hz.
REQ-003 SHALL have parameter DEV_ADDR, default 7'h1A: codec 7-bit I2C address (write byte 8'h34).
REQ-004 SHALL have port clock_ref, input, 1 bit: single clock; all state on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port start, input, 1 bit: one-cycle pulse to rerun the full configuration.
REQ-007 SHALL have port i2c_sclk, output, 1 bit: I2C clock, push-pull.
REQ-008 SHALL have port i2c_sdat, inout, 1 bit: I2C data, open-drain (drives 0 or high-Z only).
REQ-009 SHALL have port cfg_busy, output, 1 bit: sequence in progress.
REQ-010 SHALL have port cfg_done, output, 1 bit: all words written; held until next start or reset.
REQ-011 SHALL have port cfg_err, output, 1 bit: sequence aborted on NACK; held until next start or reset.

Function
REQ-012 SHALL derive tick enable every Q = CLOCK_REF/(I2C_FREQ*4) clocks (46 at defaults); all bus activity advances only on tick.
REQ-013 SHALL hold an 11-entry table of 16-bit words {reg[6:0],data[8:0]}, sent in order: 1E00, 0017, 0217, 0479, 0679, 0812, 0A00, 0C00, 0E01, 1002, 1201.
REQ-014 SHALL send one frame per word: START, 8'h34, ACK, word[15:8], ACK, word[7:0], ACK, STOP, 4-tick GAP; MSB first.
REQ-015 SHALL time each bit as 4 ticks: q0 SCL low + set SDA; q1 SCL high; q2 SCL high, sample SDA (ACK slots); q3 SCL low.
REQ-016 SHALL generate START as SDA falling while SCL high, and STOP as SDA rising while SCL high; SDA SHALL change only while SCL is low otherwise.
REQ-017 SHALL release SDA (high-Z) for every ACK slot.
REQ-018 SHALL use states IDLE, PWRUP, START, BIT, ACK, STOP, GAP, DONE, ERR.
REQ-019 SHALL transition IDLE->PWRUP after reset release or on start; PWRUP waits 256 ticks, then ->START.
REQ-020 SHALL transition GAP->START for the next word, or GAP->DONE after word 10.
REQ-021 SHALL take exactly 120 ticks per word (5520 clocks at defaults).
REQ-022 SHALL assert cfg_busy in PWRUP through GAP, and deassert it in IDLE, DONE and ERR.
REQ-023 SHALL ignore start while cfg_busy=1.
REQ-024 SHALL, on start in DONE or ERR, clear cfg_done and cfg_err on the next clock and enter PWRUP.

Reset
REQ-025 SHALL, while reset_n=0, asynchronously force i2c_sclk=1, i2c_sdat=Z, cfg_busy=0, cfg_done=0, cfg_err=0, state=IDLE, and clear all counters and the word index.
REQ-026 SHALL, on reset mid-frame, abandon the frame with no STOP and restart from word 0 after release.

Configuration
REQ-027 SHALL support macro WM8731_ACK_CHECK_EN.
REQ-028 SHALL, with WM8731_ACK_CHECK_EN defined, treat SDA=1 sampled at an ACK q2 as NACK: finish the bit, send STOP and GAP, then retry the same word; on the 4th consecutive NACK of one word, enter ERR and set cfg_err=1.
REQ-029 SHALL, with WM8731_ACK_CHECK_EN undefined, ignore ACK values, never retry, and tie cfg_err to 0.

Verification
REQ-030 SHALL verify reset release with codec model always ACKing: cfg_busy=1 next clock; cfg_done=1 after 256+11*120 ticks (1576 ticks, 72496 clocks); 11 decoded words match REQ-013.
REQ-031 SHALL verify that a bus monitor sees zero SDA transitions while SCL is high, other than START/STOP, over the full sequence.
REQ-032 SHALL verify that with ACK_CHECK on and the model NACKing word 3 once, word 3 is sent twice, 12 frames total, and cfg_done=1 with cfg_err=0.
REQ-033 SHALL verify that with ACK_CHECK on and the model always NACKing address, 4 frames are sent, then cfg_err=1, cfg_busy=0, cfg_done=0; with ACK_CHECK off, 11 frames are sent and cfg_done=1.
REQ-034 SHALL verify that reset_n pulsed low during word 5 bit 12 gives SCL=1, SDA=Z immediately, and the next frame after release carries 1E00.
REQ-035 SHALL verify that start pulsed mid-sequence has no effect, and start pulsed in DONE clears cfg_done and reruns all 11 words.
